// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction controller.
//   state_t        - controller FSM state encoding
//   OPC_* / OP_*   - opcode (IR[15:13]) and op (IR[12:11]) constants
//   VSEL_*         - one-hot writeback select codes
//   is_legal()     - true for the supported opcode/op pairs
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [3:0] VSEL_NONE   = 4'b0000;
  localparam logic [3:0] VSEL_MDATA  = 4'b0001;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
  localparam logic [3:0] VSEL_PC     = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b1000;

  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_ALU) ||
           ((opc == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction input and datapath-control bundle.
//   master modport - instruction source: drives in/load/s, observes controls
//   slave modport  - controller: samples in/load/s, drives all controls
//   state          - current FSM state, exposed for observation only
// Handshake: s is a level-sensitive start; the controller accepts it only
// while w=1 (state WAIT), and load likewise only captures `in` while w=1.
// Once accepted, the instruction runs to completion and w returns to 1.
interface cpu_controller_if;
  import cpu_pkg::*;

  logic [15:0] in;
  logic        load;
  logic        s;

  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic        sximmsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  state_t      state;

  modport master (
    output in, load, s,
    input  w, illegal, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, sximmsel, shift, ALUop, sximm8, sximm5, state
  );

  modport slave (
    input  in, load, s,
    output w, illegal, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, sximmsel, shift, ALUop, sximm8, sximm5, state
  );

endinterface

// File: rtl/cpu_controller_sign_ext.sv
// sign_ext: sign-extends an IN_W-bit field to 16 bits.
//   a_i - input field (IN_W bits)
//   y_o - 16-bit sign-extended result
module sign_ext #(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0] a_i,
  output logic [15:0]     y_o
);

  assign y_o = {{(16 - IN_W){a_i[IN_W-1]}}, a_i};

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control FSM for the 16-bit instruction set.
// Holds the instruction register and sequences the datapath strobes.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset (state WAIT, IR=0)
//   bus     - cpu_controller_if.slave: in/load/s inputs, datapath controls,
//             sign-extended immediates and the state observation port
// All control outputs are Moore: derived from state_q and ir_q only, so an
// asynchronous reset clears them as soon as state_q returns to WAIT.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  cpu_controller_if.slave    bus
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       legal, mov_imm, mov_reg, mvn, cmp, uses_a;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign legal   = is_legal(opc, op);
  assign mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
  assign mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
  assign mvn     = (opc == OPC_ALU) && (op == OP_MVN);
  assign cmp     = (opc == OPC_ALU) && (op == OP_CMP);
  // ADD/CMP/AND read Rn into A; MOV reg and MVN use a zero A operand.
  assign uses_a  = (opc == OPC_ALU) && (op != OP_MVN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    bus.w        = 1'b0;
    bus.illegal  = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.vsel     = VSEL_NONE;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.write    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    // No supported instruction selects sximm5, and sximm8 reaches the
    // register file through vsel, so the width select stays low.
    bus.sximmsel = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;

    unique case (state_q)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.load) ir_d = bus.in;
        if (bus.s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          bus.illegal = 1'b1;
          state_d     = S_WAIT;
        end else if (mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (uses_a) begin
          state_d = S_GET_A;
        end else begin
          state_d = S_GET_B;
        end
      end
      S_WRITE_IMM: begin
        bus.write    = 1'b1;
        bus.writenum = rn;
        bus.vsel     = VSEL_SXIMM8;
        state_d      = S_WAIT;
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = S_ALU;
      end
      S_ALU: begin
        bus.shift = sh;
        bus.loadc = 1'b1;
        bus.ALUop = (opc == OPC_ALU) ? op : 2'b00;
        bus.asel  = mov_reg || mvn;
        bus.loads = cmp;
        state_d   = cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        bus.write    = 1'b1;
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        state_d      = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign bus.state = state_q;

  sign_ext #(.IN_W(8)) u_sx8 (.a_i(ir_q[7:0]), .y_o(bus.sximm8));
  sign_ext #(.IN_W(5)) u_sx5 (.a_i(ir_q[4:0]), .y_o(bus.sximm5));

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic clk;
  logic reset_n;
  cpu_controller_if bus();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  localparam int W = 55;
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  logic [15:0] ir_m;   // model of the instruction register

  // strobe mask bits: loada loadb loadc loads write asel bsel sximmsel
  localparam logic [7:0] SB_LA = 8'h80, SB_LB = 8'h40, SB_LC = 8'h20,
                         SB_LS = 8'h10, SB_WR = 8'h08, SB_AS = 8'h04;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    check(name, W'(got), W'(want));
  endtask

  function automatic logic [15:0] sext(input logic [15:0] ir, input int bits);
    int v;
    v = int'(ir) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  function automatic logic [W-1:0] mk(input logic ill, input logic [2:0] rdn,
                                      input logic [2:0] wrn, input logic [3:0] vs,
                                      input logic [7:0] strb, input logic [1:0] sh,
                                      input logic [1:0] alu, input logic [15:0] ir);
    return {ill, rdn, wrn, vs, strb, sh, alu, sext(ir, 8), sext(ir, 5)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.illegal, bus.readnum, bus.writenum, bus.vsel,
            bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write,
            bus.asel, bus.bsel, bus.sximmsel, bus.shift, bus.ALUop,
            bus.sximm8, bus.sximm5};
  endfunction

  // Reference model: the busy-cycle control sequence an instruction produces,
  // built from the instruction's meaning rather than from a state machine.
  function automatic void push_expected(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit is_mimm, is_mreg, is_add, is_cmp, is_and, is_mvn;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    is_mimm = (ir[15:11] == 5'b11010);
    is_mreg = (ir[15:11] == 5'b11000);
    is_add  = (ir[15:11] == 5'b10100);
    is_cmp  = (ir[15:11] == 5'b10101);
    is_and  = (ir[15:11] == 5'b10110);
    is_mvn  = (ir[15:11] == 5'b10111);
    if (!(is_mimm || is_mreg || is_add || is_cmp || is_and || is_mvn)) begin
      exp_q.push_back(mk(1'b1, 3'd0, 3'd0, 4'b0000, 8'h00, 2'b00, 2'b00, ir));
      return;
    end
    exp_q.push_back(mk(1'b0, 3'd0, 3'd0, 4'b0000, 8'h00, 2'b00, 2'b00, ir));
    if (is_mimm) begin
      exp_q.push_back(mk(1'b0, 3'd0, rn, 4'b0010, SB_WR, 2'b00, 2'b00, ir));
      return;
    end
    if (is_add || is_cmp || is_and)
      exp_q.push_back(mk(1'b0, rn, 3'd0, 4'b0000, SB_LA, 2'b00, 2'b00, ir));
    exp_q.push_back(mk(1'b0, rm, 3'd0, 4'b0000, SB_LB, 2'b00, 2'b00, ir));
    exp_q.push_back(mk(1'b0, 3'd0, 3'd0, 4'b0000,
                       SB_LC | (is_cmp ? SB_LS : 8'h00) | ((is_mreg || is_mvn) ? SB_AS : 8'h00),
                       sh, is_mreg ? 2'b00 : op, ir));
    if (!is_cmp)
      exp_q.push_back(mk(1'b0, 3'd0, rd, 4'b1000, SB_WR, 2'b00, 2'b00, ir));
  endfunction

  function automatic int latency_of(input logic [15:0] ir);
    case (ir[15:11])
      5'b11010:                   return 2;
      5'b11000, 5'b10111:         return 4;
      5'b10101:                   return 4;
      5'b10100, 5'b10110:         return 5;
      default:                    return 1;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      checks++;
      if (bus.vsel == 4'b0100) begin
        failures++;
        $display("FAIL vsel_pc got=%b t=%0t", bus.vsel, $time);
      end
      if (!bus.w) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_busy got=%h want=none t=%0t", dut_vec(), $time);
        end else begin
          check("busy_cycle", dut_vec(), exp_q.pop_front());
        end
      end else begin
        check("idle_strobes", W'(dut_vec() >> 32), '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    bus.in   = 16'($urandom);
    bus.load = 1'($urandom_range(0, 1));
    bus.s    = 1'b0;
    if (bus.load) ir_m = bus.in;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check1("w_idle_hold", bus.w, 1'b1);
  endtask

  // Called at posedge+1 with the DUT in WAIT.
  task automatic issue(input logic [15:0] instr, input bit do_load);
    int busy;
    if (do_load) ir_m = instr;
    push_expected(ir_m);
    bus.in   = instr;
    bus.load = do_load;
    bus.s    = 1'b1;
    @(posedge clk); #1;
    busy = 0;
    // load, s and in are all don't-care while busy: scramble them
    while (!bus.w && busy < 20) begin
      busy++;
      bus.in   = 16'($urandom);
      bus.load = 1'($urandom_range(0, 1));
      bus.s    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.load = 1'b0;
    bus.s    = 1'b0;
    if (busy >= 20) begin
      checks++; failures++;
      $display("FAIL timeout_w instr=%h busy=%0d", ir_m, busy);
    end else begin
      check("latency", W'(busy), W'(latency_of(ir_m)));
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10101;
      4: r[15:11] = 5'b10110;
      5: r[15:11] = 5'b10111;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    logic [15:0] dir [7];
    dir[0] = 16'hD0F0; dir[1] = 16'hA148; dir[2] = 16'hA900; dir[3] = 16'hB860;
    dir[4] = 16'hE000; dir[5] = 16'hC0A9; dir[6] = 16'hB2C5;

    bus.in = '0; bus.load = 1'b0; bus.s = 1'b0;
    reset_n = 1'b0;
    ir_m = '0;
    #1;
    check1("reset_w", bus.w, 1'b1);
    check("reset_outputs", dut_vec(), '0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    foreach (dir[i]) begin
      issue(dir[i], 1'b1);
      if (i % 2 == 1) idle_cycle();
    end
    issue(16'h0000, 1'b0);   // re-run the previous IR without loading

    // reset during GET_B of an ADD
    ir_m = 16'hA148;
    push_expected(ir_m);
    bus.in = ir_m; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("pre_reset_loadb", bus.loadb, 1'b1);
    #1;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check1("async_reset_w", bus.w, 1'b1);
    check("async_reset_outputs", dut_vec(), '0);
    exp_q.delete();
    ir_m = '0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (3) begin
      bus.in = 16'($urandom); bus.load = 1'b0; bus.s = 1'b0;
      @(posedge clk); #1;
      check1("wait_after_reset", bus.w, 1'b1);
    end
    issue(16'hD0F0, 1'b0);   // IR was cleared, so this decodes 0000 as illegal

    for (int n = 0; n < 40; n++) begin
      issue(rand_instr(), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    check("queue_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters: none; all widths are fixed by the 16-bit instruction set.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 in  input  16  instruction word; captured into the internal IR.
REQ-005 load  input  1  IR load enable; honoured only in state WAIT.
REQ-006 s  input  1  start, level-sensitive; sampled only in WAIT.
REQ-007 w  output  1  idle/ready: 1 exactly when state is WAIT.
REQ-008 illegal  output  1  one-cycle pulse when an unsupported opcode/op pair is decoded.
REQ-009 readnum, writenum  output  3 each  register-file read and write indices.
REQ-010 vsel  output  4  one-hot writeback select: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C feedback.
REQ-011 loada, loadb, loadc, loads, write  output  1 each  datapath load/write strobes.
REQ-012 asel, bsel, sximmsel  output  1 each  A-operand zero select, B-operand immediate select, immediate width select (1 = sximm8).
REQ-013 shift, ALUop  output  2 each  shifter code and ALU operation.
REQ-014 sximm8, sximm5  output  16 each  sign-extended IR[7:0] and IR[4:0].

Function
REQ-015 IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-016 Supported instructions: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All other opcode/op pairs are illegal.
REQ-017 States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG. Each state lasts one cycle except WAIT.
REQ-018 WAIT transitions to DECODE when s=1; otherwise WAIT is held. If s is still high on return to WAIT, the next instruction starts immediately.
REQ-019 DECODE transitions: MOV #imm goes to WRITE_IMM; ADD/CMP/AND go to GET_A; MOV reg/MVN go to GET_B; illegal goes to WAIT with illegal=1 for that cycle.
REQ-020 WRITE_IMM asserts write=1, writenum=Rn, vsel=0010, then goes to WAIT.
REQ-021 GET_A asserts readnum=Rn, loada=1, then goes to GET_B.
REQ-022 GET_B asserts readnum=Rm, loadb=1, then goes to ALU.
REQ-023 ALU state drives shift=sh, bsel=0, loadc=1 and:
- ALUop=op for opcode 101; ALUop=00 for MOV reg.
- asel=1 for MOV reg/MVN, else 0.
- loads=1 only for CMP.
REQ-024 ALU state exits to WAIT for CMP and to WRITE_REG for all other instructions.
REQ-025 WRITE_REG asserts write=1, writenum=Rd, vsel=1000, then goes to WAIT.
REQ-026 Start-to-w latency: MOV #imm 2 cycles; MOV reg/MVN 4; CMP 4; ADD/AND 5.
REQ-027 Every strobe not named for a state SHALL be 0. Default values: vsel=0000, readnum=0, writenum=0, shift=00, ALUop=00, sximmsel=0. vsel SHALL never be 0100.
REQ-028 Outputs are Moore: a function of the current state and IR only. sximm8/sximm5 are combinational from IR at all times.
REQ-029 load outside WAIT SHALL be ignored; IR stays stable for the whole instruction.

Reset
REQ-030 reset_n=0 forces state WAIT and IR=0000 immediately, including mid-instruction. While reset is active: w=1, illegal=0, all strobes 0.

Structure
REQ-031 Shared package cpu_pkg holds the state encoding, opcode/op constants and vsel one-hot codes.
REQ-032 One sub-module, sign_ext (parameterised input width to 16 bits), is instantiated twice.

Verification
REQ-033 MOV #imm: in=16'hD0F0, load, s=1 -> WRITE_IMM cycle shows write=1, writenum=0, vsel=0010, sximm8=16'hFFF0; w=1 on the next cycle.
REQ-034 ADD: in=16'hA148 -> readnum=1/loada; readnum=0/loadb; shift=01, ALUop=00, asel=0, loadc=1; write=1, writenum=2, vsel=1000; w returns after 5 cycles.
REQ-035 CMP: in=16'hA900 -> loads=1 in the ALU state, ALUop=01, write never 1, w returns after 4 cycles.
REQ-036 MVN: in=16'hB860 -> GET_A skipped, asel=1, ALUop=11, writenum=3.
REQ-037 Illegal: in=16'hE000 -> illegal=1 for one cycle, no write, w=1 two cycles after s.
REQ-038 Reset mid-op: reset_n low during GET_B -> w=1 and all strobes 0 asynchronously; after release, WAIT is held until s=1.
